demux_slave: RTL
================

Name: demux_slave

Overview:
- Write-side counterpart of the 4:1 slave read-select mux.
- Takes one 32-bit word per transfer from a single upstream source and delivers it to one of four destination channels (A..D), or to all four in broadcast mode.
- Provides a one-entry holding register with valid/ready handshakes on both sides, so upstream and destinations can stall independently.
- Sits between the DLX datapath write port and four slave/lane sinks.

Parameters:
- DATA_W, 32, data word width.
- CNT_W, 16, width of per-channel delivery counters (optional feature only).

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- IN_DATA  in  DATA_W  word to deliver.
- IN_SEL  in  2  destination: 00=A, 01=B, 10=C, 11=D.
- IN_BCAST  in  1  1=deliver to all four channels; IN_SEL ignored.
- IN_VALID  in  1  upstream offers word.
- IN_READY  out  1  block accepts word this cycle.
- OUT_DATA  out  DATA_W  held word, common to all channels.
- OUT_VALID  out  4  bit i = word pending for channel i (bit0=A .. bit3=D).
- OUT_READY  in  4  bit i = channel i accepts this cycle.
- BUSY  out  1  1 while any delivery is pending.

Behaviour:
- Reset: one synchronous reset, active-low, on CLK; it dominates all other events in that cycle.
  - After reset: PEND=4'b0000, OUT_DATA=0, OUT_VALID=0, BUSY=0, state IDLE.
  - IN_READY=1 as soon as RST_N is high.
  - A pending word is discarded by reset, with no further delivery.
- State: PEND[3:0] mask register; OUT_VALID=PEND; BUSY=|PEND.
- FSM:
  - IDLE: PEND==0.
  - HOLD: PEND!=0.
- Channel completion: bit i completes in a cycle when PEND[i] & OUT_READY[i]. OUT_READY on non-pending channels is ignored.
- Completion event: all remaining bits complete this cycle, i.e. (PEND & ~OUT_READY)==0.
- IN_READY = (PEND==0) | completion event. This is a combinational path from OUT_READY to IN_READY by design; it gives full throughput.
- Accept: IN_VALID & IN_READY.
  - OUT_DATA <= IN_DATA.
  - PEND <= IN_BCAST ? 4'b1111 : one-hot(IN_SEL).
- Latency: an accepted word appears on OUT_DATA/OUT_VALID the next cycle. A unicast burst with a ready destination sustains 1 word/cycle.
- HOLD without completion: PEND <= PEND & ~OUT_READY. OUT_DATA is stable.
- HOLD with completion and no accept: PEND <= 0, return to IDLE.
- HOLD with completion and accept in the same cycle: the new word is loaded and the state stays HOLD (back-to-back).
- Broadcast: channels may accept in any order and in different cycles. Each channel sees exactly one OUT_VALID&OUT_READY handshake per word. The next word is not accepted until the last channel completes.
- OUT_VALID bits never deassert before their handshake. OUT_DATA never changes while any OUT_VALID bit is set, except in a completion+accept cycle.
- IN_VALID low: no state change other than draining PEND.

Optional Feature:
- Macro: DEMUX_SLAVE_CNT_EN.
- Defined:
  - Adds output CNT_A, CNT_B, CNT_C, CNT_D (each CNT_W): count of completed handshakes per channel.
  - Counters reset to 0 and wrap from 2^CNT_W-1 to 0.
  - A broadcast word increments each counter in the cycle that channel completes.
  - Adds input CNT_CLR (1). CNT_CLR=1 zeroes all counters next cycle; CLR has priority over an increment in the same cycle.
- Undefined: the counter ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package dlx_slave_pkg holds:
  - Channel select encodings: SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_D=2'b11.
  - Constant NUM_CH=4.
  - Function onehot4(sel). The same encodings also drive mux_slave SEL_MUX.
- Natural sub-module: demux_slave_cnt, one wrapping counter with clear and increment, instantiated four times under DEMUX_SLAVE_CNT_EN.

Test Plan:
- Reset:
  - Stimulus: RST_N=0 two cycles with IN_VALID=1, then release.
  - Required: OUT_VALID=0000, OUT_DATA=0, BUSY=0 during reset; IN_READY=1 after release.
- Unicast, ready destination:
  - Stimulus: IN_DATA=32'hDEADBEEF, IN_SEL=10, OUT_READY=1111.
  - Required: next cycle OUT_VALID=0100, OUT_DATA=DEADBEEF; handshake completes; IN_READY stays 1.
- Stalled destination:
  - Stimulus: IN_SEL=01, OUT_READY[1]=0 for 5 cycles, then 1.
  - Required: OUT_VALID=0010 held 6 cycles; OUT_DATA stable; IN_READY=0 during the stall.
- Broadcast, staggered acceptance:
  - Stimulus: IN_BCAST=1, IN_DATA=32'h12345678; OUT_READY=0001, then 0100, then 1010.
  - Required: OUT_VALID steps 1111 -> 1110 -> 1010 -> 0000; IN_READY=1 only in the third cycle.
- Back-to-back:
  - Stimulus: words 1,2,3 to A, B, D on consecutive cycles, all OUT_READY=1.
  - Required: OUT_VALID=0001, 0010, 1000 on consecutive cycles with matching data; IN_READY never 0.
- Counters (with DEMUX_SLAVE_CNT_EN, CNT_W=16):
  - Stimulus: preload via 65535 deliveries to A, then one more.
  - Required: CNT_A wraps to 0.
  - Stimulus: CNT_CLR asserted in the same cycle as a delivery to B.
  - Required: CNT_B=0.

Source files
------------

// File: rtl/dlx_slave_pkg.sv
// Shared definitions for the DLX slave-side select logic.
// The channel encodings here are also used by the read-side mux_slave select.
package dlx_slave_pkg;

  localparam int NUM_CH = 4;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

  // Holding-register occupancy: IDLE when nothing is pending, HOLD otherwise.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } demux_state_t;

  // Channel select to one-hot pending mask (bit0=A .. bit3=D).
  function automatic logic [NUM_CH-1:0] onehot4(input logic [1:0] sel);
    logic [NUM_CH-1:0] mask;
    mask = '0;
    case (sel)
      SEL_A:   mask = 4'b0001;
      SEL_B:   mask = 4'b0010;
      SEL_C:   mask = 4'b0100;
      default: mask = 4'b1000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/demux_slave_cnt.sv
// One wrapping handshake counter with synchronous clear.
// Clear wins over increment in the same cycle.
module demux_slave_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear, else increment with natural wrap, else hold.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/demux_slave.sv
// demux_slave: one-entry holding register that steers a word from a single
// upstream source to one of four channels (A..D), or to all four in
// broadcast mode. Each channel handshakes independently; the next word is
// taken in the same cycle the last pending channel completes.
// Optional per-channel delivery counters: define DEMUX_SLAVE_CNT_EN.
module demux_slave
  import dlx_slave_pkg::*;
#(
  parameter int DATA_W = 32
`ifdef DEMUX_SLAVE_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic [1:0]        IN_SEL,
  input  logic              IN_BCAST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [NUM_CH-1:0] OUT_VALID,
  input  logic [NUM_CH-1:0] OUT_READY,
  output logic              BUSY
`ifdef DEMUX_SLAVE_CNT_EN
  , input  logic             CNT_CLR,
  output logic [CNT_W-1:0]   CNT_A,
  output logic [CNT_W-1:0]   CNT_B,
  output logic [CNT_W-1:0]   CNT_C,
  output logic [CNT_W-1:0]   CNT_D
`endif
);

  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [DATA_W-1:0] data_q, data_d;
  demux_state_t      state_q, state_d;

  logic complete;
  logic in_ready;
  logic accept;

  // Handshake decode and next pending mask / held word.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    complete = ((pend_q & ~OUT_READY) == '0);
    // The OUT_READY -> IN_READY path is combinational on purpose: it lets a
    // new word load in the cycle the old one drains, giving 1 word/cycle.
    in_ready = (pend_q == '0) | complete;
    accept   = IN_VALID & in_ready;
    pend_d   = pend_q & ~OUT_READY;
    data_d   = data_q;
    if (accept) begin
      data_d = IN_DATA;
      pend_d = IN_BCAST ? '1 : onehot4(IN_SEL);
    end
  end

  // FSM next state: HOLD while anything remains pending after this cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_HOLD;
      ST_HOLD: if (pend_d == '0) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, pending mask and held word; reset discards any pending word.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
    end
  end

  assign IN_READY  = in_ready;
  assign OUT_DATA  = data_q;
  assign OUT_VALID = pend_q;
  assign BUSY      = |pend_q;

`ifdef DEMUX_SLAVE_CNT_EN
  logic [NUM_CH-1:0] done;
  logic [CNT_W-1:0]  cnt [NUM_CH];

  assign done = pend_q & OUT_READY;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
    demux_slave_cnt #(.CNT_W(CNT_W)) u_cnt (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .clr_i   (CNT_CLR),
      .inc_i   (done[i]),
      .count_o (cnt[i])
    );
  end

  assign CNT_A = cnt[0];
  assign CNT_B = cnt[1];
  assign CNT_C = cnt[2];
  assign CNT_D = cnt[3];
`endif

endmodule
